// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate selectors, ALU encodings
// and the control half of the ID/EX bundle.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_NONE} imm_sel_e;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic [2:0] funct3;
    logic [3:0] alu_ctrl;
    logic [1:0] mem_to_reg;
    logic       op_a_pc;
    logic       op_b_imm;
    logic       load;
    logic       store;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       reg_write;
    logic       illegal;
  } idex_t;

  function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_sel_e sel);
    case (sel)
      IMM_I:   gen_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   gen_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   gen_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   gen_imm = {instr[31:12], 12'b0};
      default: gen_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_reg_bank.sv
// Register bank, two async read ports and one write port; x0 is hardwired zero.
// Build option: DECODE_WB_BYPASS_EN forwards same-cycle writeback data to the reads.
module reg_bank #(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddress-1:0] rs1,
  input  logic [RegAddress-1:0] rs2,
  output logic [DataWidth-1:0]  rs1_data,
  output logic [DataWidth-1:0]  rs2_data,
  input  logic                  wb_en,
  input  logic [RegAddress-1:0] wb_rd,
  input  logic [DataWidth-1:0]  wb_data
);

  localparam int Depth = 2 ** RegAddress;

  logic [DataWidth-1:0] regs [Depth];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_rd == rs1) rs1_data = wb_data;
`endif
    if (rs1 == '0) rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_rd == rs2) rs2_data = wb_data;
`endif
    if (rs2 == '0) rs2_data = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with registered ID/EX bundle, load-use stall and stall counter.
// Build option: DECODE_WB_BYPASS_EN (otherwise a same-cycle writeback read stalls one cycle).
module decode_stage
  import decode_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [DataWidth-1:0]  if_instr,
  input  logic [DataWidth-1:0]  if_pc,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [RegAddress-1:0] wb_rd,
  input  logic [DataWidth-1:0]  wb_data,
  input  logic                  ex_ready,
  output logic                  id_valid,
  output logic [DataWidth-1:0]  id_pc,
  output logic [DataWidth-1:0]  id_rs1_data,
  output logic [DataWidth-1:0]  id_rs2_data,
  output logic [DataWidth-1:0]  id_imm,
  output logic [RegAddress-1:0] id_rs1,
  output logic [RegAddress-1:0] id_rs2,
  output logic [RegAddress-1:0] id_rd,
  output logic [2:0]            id_funct3,
  output logic [3:0]            id_alu_ctrl,
  output logic [1:0]            id_mem_to_reg,
  output logic                  id_op_a_pc,
  output logic                  id_op_b_imm,
  output logic                  id_load,
  output logic                  id_store,
  output logic                  id_branch,
  output logic                  id_jal,
  output logic                  id_jalr,
  output logic                  id_reg_write,
  output logic                  id_illegal,
  output logic [31:0]           stall_cnt
);

  logic [31:0]           instr;
  logic [6:0]            opcode;
  logic [RegAddress-1:0] rs1, rs2, rd;
  logic [DataWidth-1:0]  rs1_data, rs2_data, imm_ext;
  logic                  use_rs1, use_rs2;
  imm_sel_e              imm_sel;
  idex_t                 dec, id_ctrl;
  logic                  load_hz, hz, advance;

  assign instr   = if_instr[31:0];
  assign opcode  = instr[6:0];
  assign rs1     = RegAddress'(instr[19:15]);
  assign rs2     = RegAddress'(instr[24:20]);
  assign rd      = RegAddress'(instr[11:7]);
  assign imm_ext = DataWidth'($signed(gen_imm(instr, imm_sel)));

  always_comb begin
    dec        = '0;
    dec.funct3 = instr[14:12];
    imm_sel    = IMM_NONE;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_op(instr[14:12], instr[30]);
      end
      OP_IMM: begin
        use_rs1 = 1'b1; imm_sel = IMM_I;
        dec.reg_write = 1'b1; dec.op_b_imm = 1'b1;
        // only SRAI uses bit 30; for other I-ALU ops it is immediate payload
        dec.alu_ctrl  = alu_op(instr[14:12], instr[14:12] == 3'b101 && instr[30]);
      end
      OP_LOAD: begin
        use_rs1 = 1'b1; imm_sel = IMM_I;
        dec.load = 1'b1; dec.reg_write = 1'b1; dec.op_b_imm = 1'b1;
        dec.mem_to_reg = 2'd1;
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = IMM_S;
        dec.store = 1'b1; dec.op_b_imm = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = IMM_B;
        dec.branch = 1'b1; dec.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        imm_sel = IMM_J;
        dec.jal = 1'b1; dec.reg_write = 1'b1; dec.op_a_pc = 1'b1; dec.op_b_imm = 1'b1;
        dec.mem_to_reg = 2'd2;
      end
      OP_JALR: begin
        use_rs1 = 1'b1; imm_sel = IMM_I;
        dec.jalr = 1'b1; dec.reg_write = 1'b1; dec.op_b_imm = 1'b1;
        dec.mem_to_reg = 2'd2;
      end
      OP_LUI: begin
        imm_sel = IMM_U;
        dec.reg_write = 1'b1; dec.op_b_imm = 1'b1; dec.alu_ctrl = ALU_PASS_B;
      end
      OP_AUIPC: begin
        imm_sel = IMM_U;
        dec.reg_write = 1'b1; dec.op_a_pc = 1'b1; dec.op_b_imm = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (rd == '0) dec.reg_write = 1'b0;
  end

  reg_bank #(.DataWidth(DataWidth), .RegAddress(RegAddress)) u_reg_bank (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  assign load_hz = if_valid && id_valid && id_ctrl.load && id_rd != '0 &&
                   ((use_rs1 && rs1 == id_rd) || (use_rs2 && rs2 == id_rd));

`ifdef DECODE_WB_BYPASS_EN
  assign hz = load_hz;
`else
  // without forwarding, wait one cycle for the write to land in the bank
  assign hz = load_hz || (if_valid && wb_en && wb_rd != '0 &&
                          ((use_rs1 && rs1 == wb_rd) || (use_rs2 && rs2 == wb_rd)));
`endif

  assign advance  = !id_valid || ex_ready;
  assign if_ready = advance && !hz && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_ctrl     <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (advance) begin
      if (if_valid && if_ready) begin
        id_valid    <= 1'b1;
        id_pc       <= if_pc;
        id_rs1_data <= rs1_data;
        id_rs2_data <= rs2_data;
        id_imm      <= imm_ext;
        id_rs1      <= rs1;
        id_rs2      <= rs2;
        id_rd       <= rd;
        id_ctrl     <= dec;
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hz && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign id_funct3     = id_ctrl.funct3;
  assign id_alu_ctrl   = id_ctrl.alu_ctrl;
  assign id_mem_to_reg = id_ctrl.mem_to_reg;
  assign id_op_a_pc    = id_ctrl.op_a_pc;
  assign id_op_b_imm   = id_ctrl.op_b_imm;
  assign id_load       = id_ctrl.load;
  assign id_store      = id_ctrl.store;
  assign id_branch     = id_ctrl.branch;
  assign id_jal        = id_ctrl.jal;
  assign id_jalr       = id_ctrl.jalr;
  assign id_reg_write  = id_ctrl.reg_write;
  assign id_illegal    = id_ctrl.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RV32I decode stage with a registered ID/EX output and valid/ready handshakes on both sides. Sits between fetch and execute: decodes the instruction, generates the immediate, reads the register bank with writeback bypass, detects load-use hazards, and presents one registered decode bundle per instruction to execute. Bubbles are inserted on hazard or flush, and stall cycles are counted for performance monitoring.

## Interface
Parameters:
- DataWidth, 32, datapath and instruction width.
- RegAddress, 5, register index width; bank holds 2**RegAddress registers.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  decode accepts the instruction this cycle.
- if_instr  in  DataWidth  instruction word.
- if_pc  in  DataWidth  instruction address.
- flush  in  1  kill the instruction in ID/EX and the one on the fetch interface.
- wb_en  in  1  writeback enable.
- wb_rd  in  RegAddress  writeback destination.
- wb_data  in  DataWidth  writeback data.
- ex_ready  in  1  execute accepts the ID/EX bundle.
- id_valid  out  1  ID/EX bundle valid.
- id_pc, id_rs1_data, id_rs2_data, id_imm  out  DataWidth each  registered PC, operands and selected immediate.
- id_rs1, id_rs2, id_rd  out  RegAddress each  register indices.
- id_funct3  out  3  instruction[14:12].
- id_alu_ctrl  out  4  ALU operation.
- id_mem_to_reg  out  2  writeback source: 0 ALU, 1 memory, 2 PC+4.
- id_op_a_pc, id_op_b_imm, id_load, id_store, id_branch, id_jal, id_jalr, id_reg_write, id_illegal  out  1 each  control flags.
- stall_cnt  out  32  saturating count of hazard-stall cycles.

## Operation
- Decode is combinational from if_instr. Opcode classes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- Immediates are I, S, B, J and U, sign-extended to DataWidth. The immediate is selected by class. R-type yields 0.
- An unknown opcode sets id_illegal=1 and forces id_reg_write, id_load, id_store and id_branch to 0.
- id_rd=0 forces id_reg_write=0.
- Register bank:
  - x0 reads 0; writes to x0 are ignored.
  - Writes happen on the clk edge when wb_en=1.
- Register use:
  - rs1 is used by all classes except LUI, AUIPC and JAL.
  - rs2 is used by R, STORE and BRANCH.
- Load-use hazard (hz): id_valid && id_load && id_rd!=0 && (id_rd matches a used rs1/rs2 of if_instr) && if_valid.
- if_ready = (!id_valid || ex_ready) && !hz && !flush.
- ID/EX update, only when !id_valid || ex_ready:
  - If if_valid && if_ready, load the new bundle with id_valid=1.
  - Otherwise set id_valid=0 (bubble).
- ID/EX fields hold while id_valid && !ex_ready.
- Flush has priority over everything: next cycle id_valid=0, and the fetch-side instruction is not accepted.
- stall_cnt increments on each cycle with hz=1 and saturates at 2**32-1.

## Timing
- Latency: 1 cycle from an accepted if handshake to id_valid.
- Throughput is 1 instruction per cycle absent hazards.
- A load-use hazard costs exactly one bubble. The next cycle the load has left ID/EX, hz clears, and the instruction is accepted.
- A writeback in the same cycle as a read of the same register is covered by Configuration.
- On reset:
  - All ID/EX outputs are 0, including id_valid.
  - stall_cnt=0.
  - All registers are 0.
  - if_ready=1 after reset release.
- Reset mid-stall discards the held bundle and the stall.
- flush and hz in the same cycle: flush wins; the hz cycle still counts in stall_cnt.
- ex_ready=0 with hz=1: the bundle holds and if_ready=0.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - A read whose index equals wb_rd with wb_en=1 and index!=0 returns wb_data in the same cycle.
- Undefined:
  - Reads return the pre-write value.
  - The hazard term is extended with (wb_en && wb_rd!=0 && wb_rd matches a used rs). This stalls one cycle, which is counted in stall_cnt.

## Structure
- decode_pkg holds:
  - the opcode constants;
  - the imm_sel_e enum {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_NONE};
  - the alu_ctrl encodings;
  - the idex_t struct of the ID/EX bundle.
- One sub-module, reg_bank: 2**RegAddress x DataWidth, two read ports and one write port, asynchronous active-low reset, bypass under DECODE_WB_BYPASS_EN.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with ex_ready=1 → after 1 cycle: id_valid=1, id_imm=5, id_rd=1, id_reg_write=1, id_op_b_imm=1.
- Write x2=0xDEADBEEF, then issue `add x3,x2,x2` → id_rs1_data=id_rs2_data=0xDEADBEEF.
- `lw x5,0(x1)` followed by `add x6,x5,x0`:
  - one cycle with if_ready=0 and id_valid=0 (bubble);
  - the add is then accepted;
  - stall_cnt=1.
- ex_ready=0 for 3 cycles with a valid bundle → all id_* outputs are stable and if_ready=0; the bundle is released on ex_ready=1.
- flush asserted while id_valid=1 and if_valid=1 → next cycle id_valid=0 and the fetch instruction is not consumed.
- Same-cycle wb_en=1, wb_rd=7, wb_data=0x1234 while decoding `add x8,x7,x0`:
  - bypass build: id_rs1_data=0x1234, no stall;
  - non-bypass build: one stall, then 0x1234.
